// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl: time-shared 2x2 signed 2-bit matrix multiply sequencer with valid/ready in and out.
// Optional MATMUL_SEQ_JOB_CNT_EN adds an 8-bit completed-job counter output.
module matmul_seq_ctrl #(
    parameter int OUT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           a_flat,
    input  logic [7:0]           b_flat,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*OUT_W-1:0]   c_flat,
    output logic                 err
`ifdef MATMUL_SEQ_JOB_CNT_EN
    ,output logic [7:0]          job_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t                  state_q;
    logic [2:0]              k_q;
    logic [7:0]              a_q, b_q;
    logic [3:0][OUT_W-1:0]   c_q;
    logic                    in_ready_q, out_valid_q, err_q;
    logic                    bad_d;
    logic [1:0]              a_e, b_e;
    logic [OUT_W-1:0]        prod_d;
`ifdef MATMUL_SEQ_JOB_CNT_EN
    logic [7:0]              job_cnt_q;
    assign job_cnt = job_cnt_q;
`endif
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign c_flat    = c_q;
    assign err       = err_q;
    always_comb begin
        bad_d = 1'b0;
        for (int n = 0; n < 4; n++)
            bad_d = bad_d | (a_flat[2*n +: 2] == 2'b10) | (b_flat[2*n +: 2] == 2'b10);
    end
    // step k picks a[k2][k0] and b[k0][k1]; low OUT_W bits of the product are exact in two's complement
    assign a_e    = a_q[{k_q[2], k_q[0], 1'b0} +: 2];
    assign b_e    = b_q[{k_q[0], k_q[1], 1'b0} +: 2];
    assign prod_d = {{(OUT_W-2){a_e[1]}}, a_e} * {{(OUT_W-2){b_e[1]}}, b_e};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
`ifdef MATMUL_SEQ_JOB_CNT_EN
            job_cnt_q   <= '0;
`endif
        end else if (ena) begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q         <= a_flat;
                    b_q         <= b_flat;
                    c_q         <= '0;
                    k_q         <= '0;
                    err_q       <= bad_d;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= bad_d;
                    state_q     <= bad_d ? DONE : RUN;
                end
                RUN: begin
                    c_q[k_q[2:1]] <= c_q[k_q[2:1]] + prod_d;
                    k_q           <= k_q + 3'd1;
                    if (k_q == 3'd7) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
`ifdef MATMUL_SEQ_JOB_CNT_EN
                    job_cnt_q   <= job_cnt_q + 8'd1;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// tb_matmul_seq_ctrl: directed plus randomized jobs checked against an arithmetic matrix-product model.
module tb_matmul_seq_ctrl;
    localparam int W = 4;
    logic           clk = 1'b0, rst_n = 1'b0, ena = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0]     a_flat = '0, b_flat = '0;
    logic           in_ready, out_valid, err;
    logic [4*W-1:0] c_flat;
    int             n_cmp = 0, n_bad = 0, jobs = 0;
`ifdef MATMUL_SEQ_JOB_CNT_EN
    logic [7:0]     job_cnt;
    localparam int  N_RND = 257;
`else
    localparam int  N_RND = 20;
`endif
    localparam logic [7:0] BA = 8'b01_11_00_01, BB = 8'b01_01_11_01;

    matmul_seq_ctrl #(.OUT_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
        .a_flat(a_flat), .b_flat(b_flat), .out_valid(out_valid), .out_ready(out_ready),
        .c_flat(c_flat), .err(err)
`ifdef MATMUL_SEQ_JOB_CNT_EN
        , .job_cnt(job_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int el(input logic [7:0] x, input int n);
        logic [1:0] v;
        v = x[2*n +: 2];
        return $signed(v);
    endfunction

    function automatic logic [4*W-1:0] model(input logic [7:0] a, input logic [7:0] b, output logic e);
        logic [4*W-1:0] r;
        int s;
        e = 1'b0;
        r = '0;
        for (int n = 0; n < 4; n++)
            if (el(a, n) == -2 || el(b, n) == -2) e = 1'b1;
        if (!e)
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++) begin
                    s = 0;
                    for (int l = 0; l < 2; l++) s += el(a, 2*i+l) * el(b, 2*l+j);
                    r[(2*i+j)*W +: W] = s[W-1:0];
                end
        return r;
    endfunction

    function automatic logic [7:0] rnd_op(input bit allow_bad);
        logic [7:0] r;
        int t;
        for (int n = 0; n < 4; n++) begin
            t = $urandom_range(0, 2);
            r[2*n +: 2] = (t == 0) ? 2'b11 : (t == 1) ? 2'b00 : 2'b01;
            if (allow_bad && $urandom_range(0, 5) == 0) r[2*n +: 2] = 2'b10;
        end
        return r;
    endfunction

    task automatic do_job(input logic [7:0] a, input logic [7:0] b, input bit gate, input int hold,
                          input bit keep_valid, input bit rnd_rdy);
        logic e;
        logic [4*W-1:0] exp_c;
        int cyc;
        exp_c = model(a, b, e);
        chk("in_ready_idle", in_ready, 1);
        a_flat = a;
        b_flat = b;
        in_valid = 1'b1;
        tick;
        if (!keep_valid) in_valid = 1'b0;
        a_flat = 8'($urandom);
        b_flat = 8'($urandom);
        cyc = 0;
        while (!out_valid && cyc < 30) begin
            if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
            if (gate && cyc == 4) begin
                ena = 1'b0;
                repeat (3) begin tick; cyc++; end
                ena = 1'b1;
            end else begin
                tick;
                cyc++;
            end
        end
        out_ready = 1'b0;
        chk("latency", cyc, e ? 0 : (gate ? 11 : 8));
        chk("out_valid", out_valid, 1);
        chk("err", err, e);
        chk("c_flat", c_flat, exp_c);
        chk("in_ready_busy", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            ena = out_ready ? 1'b0 : 1'($urandom_range(0, 1));
            tick;
            chk("hold_valid", out_valid, 1);
            chk("hold_c", c_flat, exp_c);
            chk("hold_in_ready", in_ready, 0);
        end
        ena = 1'b1;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        jobs++;
        chk("out_valid_drop", out_valid, 0);
        chk("in_ready_back", in_ready, 1);
        chk("c_after_hs", c_flat, exp_c);
        chk("err_after_hs", err, e);
`ifdef MATMUL_SEQ_JOB_CNT_EN
        chk("job_cnt", job_cnt, jobs % 256);
`endif
    endtask

    initial begin
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_c", c_flat, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        tick;
        do_job(BA, BB, 0, 0, 0, 0);
        chk("basic_c_const", c_flat, {4'd2, 4'd0, 4'hF, 4'd1});
        do_job(8'h02, 8'h00, 0, 0, 0, 0);
        chk("range_c_zero", c_flat, 0);
        chk("range_err", err, 1);
        do_job(rnd_op(0), rnd_op(0), 0, 5, 1, 0);
        do_job(rnd_op(0), rnd_op(0), 0, 0, 0, 0);
        do_job(BA, BB, 1, 0, 0, 0);
        chk("gated_c_const", c_flat, {4'd2, 4'd0, 4'hF, 4'd1});
        a_flat = BA;
        b_flat = BB;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (3) tick;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_c", c_flat, 0);
        chk("mid_rst_err", err, 0);
        jobs = 0;
`ifdef MATMUL_SEQ_JOB_CNT_EN
        chk("mid_rst_job_cnt", job_cnt, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        do_job(BA, BB, 0, 0, 0, 0);
        for (int n = 0; n < N_RND; n++)
            do_job(rnd_op(1), rnd_op(1), 0, $urandom_range(0, 2), 0, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
